// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester handshakes and the shared memory port.
// The slave view belongs to the arbiter; the master view to whatever drives it.
interface mem_arbiter_if #(
  parameter int AW = 20
);
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_ready;
  logic [31:0]   o_if_rdata;

  logic          i_dm_req;
  logic          i_dm_we;
  logic [AW-1:0] i_dm_addr;
  logic [31:0]   i_dm_wdata;
  logic [3:0]    i_dm_be;
  logic          o_dm_ready;
  logic [31:0]   o_dm_rdata;

  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [3:0]    o_mem_be;
  logic          i_mem_ack;
  logic [31:0]   i_mem_rdata;
  logic          o_owner;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_ready, o_if_rdata,
    input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
    output o_dm_ready, o_dm_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_owner,
    input  i_mem_ack, i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_ready, o_if_rdata,
    output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
    input  o_dm_ready, o_dm_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_owner,
    output i_mem_ack, i_mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data has fixed priority; a streak counter lets a waiting fetch through after MAX_DM_STREAK data grants.
module mem_arbiter #(
  parameter int AW            = 20,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mem_arbiter_if.slave bus
);
  localparam int            SW         = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          owner_q, owner_d;
  logic          if_ready_q, if_ready_d;
  logic          dm_ready_q, dm_ready_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic [SW-1:0] dm_streak_q, dm_streak_d;

  // A requester is ignored in its own ready cycle, when its req is still the stale one.
  logic if_elig_s, dm_elig_s;
  assign if_elig_s = bus.i_if_req & ~if_ready_q;
  assign dm_elig_s = bus.i_dm_req & ~dm_ready_q;

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= 32'h0000_0000;
      mem_be_q    <= 4'h0;
      owner_q     <= 1'b0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= 32'h0000_0000;
      dm_rdata_q  <= 32'h0000_0000;
      dm_streak_q <= {SW{1'b0}};
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      owner_q     <= owner_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_streak_q <= dm_streak_d;
    end
  end

  // Arbitration, grant latching and completion handling.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    owner_d     = owner_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    dm_streak_d = dm_streak_q;

    case (state_q)
      IDLE: begin
        if (dm_elig_s && (!if_elig_s || (dm_streak_q < STREAK_MAX))) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          owner_d     = 1'b1;
          mem_we_d    = bus.i_dm_we;
          mem_addr_d  = bus.i_dm_addr;
          mem_wdata_d = bus.i_dm_wdata;
          mem_be_d    = bus.i_dm_be;
          // The raw req is used here, so a stale fetch req still counts as waiting.
          if (bus.i_if_req) begin
            if (dm_streak_q < STREAK_MAX) begin
              dm_streak_d = dm_streak_q + SW'(1);
            end else begin
              dm_streak_d = dm_streak_q;
            end
          end else begin
            dm_streak_d = {SW{1'b0}};
          end
        end else if (if_elig_s) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          owner_d     = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.i_if_addr;
          mem_wdata_d = 32'h0000_0000;
          mem_be_d    = 4'hF;
          dm_streak_d = {SW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_IF: begin
        if (bus.i_mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_ready_d = 1'b1;
          if_rdata_d = bus.i_mem_rdata;
        end else begin
          state_d = BUSY_IF;
        end
      end
      BUSY_DM: begin
        if (bus.i_mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          dm_ready_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = bus.i_mem_rdata;
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
        end else begin
          state_d = BUSY_DM;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_be    = mem_be_q;
  assign bus.o_owner     = owner_q;
  assign bus.o_if_ready  = if_ready_q;
  assign bus.o_dm_ready  = dm_ready_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_dm_rdata  = dm_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_arbiter;
  int   total = 0;
  int   bad   = 0;
  logic clk   = 1'b0;
  logic rst   = 1'b1;

  mem_arbiter_if #(.AW(20)) bus ();

  mem_arbiter #(.AW(20), .MAX_DM_STREAK(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // {req, owner, we, addr, wdata, be}
  logic [58:0] mem_s;
  assign mem_s = {bus.o_mem_req, bus.o_owner, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_be};
  // {if_ready, dm_ready, if_rdata, dm_rdata}
  logic [65:0] rsp_s;
  assign rsp_s = {bus.o_if_ready, bus.o_dm_ready, bus.o_if_rdata, bus.o_dm_rdata};

  logic [31:0] exp_dm_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_if_req    = 1'b0;
    bus.i_if_addr   = 20'h0;
    bus.i_dm_req    = 1'b0;
    bus.i_dm_we     = 1'b0;
    bus.i_dm_addr   = 20'h0;
    bus.i_dm_wdata  = 32'h0;
    bus.i_dm_be     = 4'h0;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    total++; if (mem_s !== 59'h0) begin bad++; $display("FAIL reset_mem got=%h want=%h", mem_s, 59'h0); end
    total++; if (rsp_s !== 66'h0) begin bad++; $display("FAIL reset_rsp got=%h want=%h", rsp_s, 66'h0); end
    rst = 1'b0;
    bus.i_mem_ack = 1'b1;
    tick();
    total++; if ({bus.o_mem_req, bus.o_if_ready, bus.o_dm_ready} !== 3'b000) begin
      bad++; $display("FAIL idle_ack_ignored got=%b want=000", {bus.o_mem_req, bus.o_if_ready, bus.o_dm_ready});
    end
    bus.i_mem_ack = 1'b0;
    exp_dm_rdata = 32'h0;
  endtask

  task automatic test_single_fetch();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 20'h00010;
    tick();
    total++; if (mem_s !== {1'b1, 1'b0, 1'b0, 20'h00010, 32'h0, 4'hF}) begin
      bad++; $display("FAIL fetch_grant got=%h want=%h", mem_s, {1'b1, 1'b0, 1'b0, 20'h00010, 32'h0, 4'hF});
    end
    total++; if (bus.o_if_ready !== 1'b0) begin bad++; $display("FAIL fetch_early_ready got=%b want=0", bus.o_if_ready); end
    tick();
    total++; if (mem_s !== {1'b1, 1'b0, 1'b0, 20'h00010, 32'h0, 4'hF}) begin
      bad++; $display("FAIL fetch_hold got=%h want=%h", mem_s, {1'b1, 1'b0, 1'b0, 20'h00010, 32'h0, 4'hF});
    end
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h00500093;
    tick();
    total++; if ({bus.o_if_ready, bus.o_dm_ready, bus.o_mem_req} !== 3'b100) begin
      bad++; $display("FAIL fetch_ready got=%b want=100", {bus.o_if_ready, bus.o_dm_ready, bus.o_mem_req});
    end
    total++; if (bus.o_if_rdata !== 32'h00500093) begin bad++; $display("FAIL fetch_rdata got=%h want=00500093", bus.o_if_rdata); end
    bus.i_if_req    = 1'b0;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = 32'h0;
    tick();
    total++; if ({bus.o_if_ready, bus.o_mem_req} !== 2'b00) begin
      bad++; $display("FAIL fetch_pulse_width got=%b want=00", {bus.o_if_ready, bus.o_mem_req});
    end
  endtask

  task automatic test_simultaneous();
    bus.i_if_req   = 1'b1;
    bus.i_if_addr  = 20'h00044;
    bus.i_dm_req   = 1'b1;
    bus.i_dm_we    = 1'b1;
    bus.i_dm_addr  = 20'h00020;
    bus.i_dm_wdata = 32'hDEADBEEF;
    bus.i_dm_be    = 4'b0011;
    tick();
    total++; if (mem_s !== {1'b1, 1'b1, 1'b1, 20'h00020, 32'hDEADBEEF, 4'b0011}) begin
      bad++; $display("FAIL simul_dm_grant got=%h want=%h", mem_s, {1'b1, 1'b1, 1'b1, 20'h00020, 32'hDEADBEEF, 4'b0011});
    end
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'hCAFEF00D;
    tick();
    total++; if ({bus.o_if_ready, bus.o_dm_ready, bus.o_mem_req} !== 3'b010) begin
      bad++; $display("FAIL simul_dm_ready got=%b want=010", {bus.o_if_ready, bus.o_dm_ready, bus.o_mem_req});
    end
    total++; if (bus.o_dm_rdata !== exp_dm_rdata) begin bad++; $display("FAIL write_keeps_rdata got=%h want=%h", bus.o_dm_rdata, exp_dm_rdata); end
    bus.i_dm_req  = 1'b0;
    bus.i_mem_ack = 1'b0;
    tick();
    total++; if (mem_s !== {1'b1, 1'b0, 1'b0, 20'h00044, 32'h0, 4'hF}) begin
      bad++; $display("FAIL simul_if_grant got=%h want=%h", mem_s, {1'b1, 1'b0, 1'b0, 20'h00044, 32'h0, 4'hF});
    end
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h12345678;
    tick();
    total++; if ({bus.o_if_ready, bus.o_dm_ready, bus.o_if_rdata} !== {2'b10, 32'h12345678}) begin
      bad++; $display("FAIL simul_if_ready got=%h want=%h", {bus.o_if_ready, bus.o_dm_ready, bus.o_if_rdata}, {2'b10, 32'h12345678});
    end
    bus.i_if_req  = 1'b0;
    bus.i_mem_ack = 1'b0;
    tick();
  endtask

  // Fetch is withdrawn in every data ready cycle so data can win repeatedly; 1 = data grant.
  task automatic test_starvation();
    logic [9:0] exp_seq;
    int         n;
    exp_seq         = 10'b0111101111;
    n               = 0;
    bus.i_dm_req    = 1'b1;
    bus.i_dm_we     = 1'b0;
    bus.i_dm_addr   = 20'h00200;
    bus.i_dm_be     = 4'hF;
    bus.i_if_addr   = 20'h00100;
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'hA5A50000;
    for (int cyc = 0; cyc < 80 && n < 10; cyc++) begin
      if (bus.o_mem_req) begin
        total++; if (bus.o_owner !== exp_seq[n]) begin
          bad++; $display("FAIL streak_grant_%0d got=%b want=%b", n, bus.o_owner, exp_seq[n]);
        end
        n++;
        bus.i_if_req = 1'b1;
      end else if (bus.o_dm_ready) begin
        bus.i_if_req = 1'b0;
      end else begin
        bus.i_if_req = 1'b1;
      end
      tick();
    end
    total++; if (n !== 10) begin bad++; $display("FAIL streak_grant_count got=%0d want=10", n); end
    bus.i_if_req = 1'b0;
    bus.i_dm_req = 1'b0;
    tick();
    tick();
    bus.i_mem_ack = 1'b0;
    exp_dm_rdata  = 32'hA5A50000;
    total++; if (bus.o_dm_rdata !== exp_dm_rdata) begin bad++; $display("FAIL streak_dm_rdata got=%h want=%h", bus.o_dm_rdata, exp_dm_rdata); end
  endtask

  // Each port keeps req high through its ready cycle; no second access may start.
  task automatic test_stale_mask();
    for (int p = 0; p < 2; p++) begin
      if (p == 0) begin
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 20'h00030;
      end else begin
        bus.i_dm_req  = 1'b1;
        bus.i_dm_we   = 1'b0;
        bus.i_dm_addr = 20'h00031;
        bus.i_dm_be   = 4'hF;
      end
      tick();
      total++; if ({bus.o_mem_req, bus.o_owner} !== {1'b1, p[0]}) begin
        bad++; $display("FAIL stale_grant_%0d got=%b want=%b", p, {bus.o_mem_req, bus.o_owner}, {1'b1, p[0]});
      end
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = 32'h33334444 + 32'(p);
      tick();
      total++; if ({bus.o_if_ready, bus.o_dm_ready} !== {p[0] == 1'b0, p[0]}) begin
        bad++; $display("FAIL stale_ready_%0d got=%b want=%b", p, {bus.o_if_ready, bus.o_dm_ready}, {p[0] == 1'b0, p[0]});
      end
      bus.i_mem_ack = 1'b0;
      tick();
      total++; if ({bus.o_mem_req, bus.o_if_ready, bus.o_dm_ready} !== 3'b000) begin
        bad++; $display("FAIL stale_no_dup_%0d got=%b want=000", p, {bus.o_mem_req, bus.o_if_ready, bus.o_dm_ready});
      end
      bus.i_if_req = 1'b0;
      bus.i_dm_req = 1'b0;
      tick();
      total++; if (bus.o_mem_req !== 1'b0) begin bad++; $display("FAIL stale_idle_%0d got=%b want=0", p, bus.o_mem_req); end
    end
    exp_dm_rdata = 32'h33334445;
    total++; if (bus.o_dm_rdata !== exp_dm_rdata) begin bad++; $display("FAIL stale_dm_rdata got=%h want=%h", bus.o_dm_rdata, exp_dm_rdata); end
  endtask

  task automatic test_ack_latency();
    logic [58:0] exp_mem;
    int          lat;
    for (int k = 0; k < 2; k++) begin
      lat            = (k == 0) ? 0 : 7;
      bus.i_dm_req   = 1'b1;
      bus.i_dm_we    = 1'b1;
      bus.i_dm_addr  = 20'hABCDE;
      bus.i_dm_wdata = 32'h0BADF00D ^ 32'(lat);
      bus.i_dm_be    = 4'b1000;
      exp_mem        = {1'b1, 1'b1, 1'b1, 20'hABCDE, 32'h0BADF00D ^ 32'(lat), 4'b1000};
      tick();
      for (int w = 0; w < lat; w++) begin
        total++; if ({mem_s, bus.o_dm_ready} !== {exp_mem, 1'b0}) begin
          bad++; $display("FAIL lat%0d_wait%0d got=%h want=%h", lat, w, {mem_s, bus.o_dm_ready}, {exp_mem, 1'b0});
        end
        tick();
      end
      total++; if (mem_s !== exp_mem) begin bad++; $display("FAIL lat%0d_ack_cycle got=%h want=%h", lat, mem_s, exp_mem); end
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = 32'h77778888;
      tick();
      total++; if ({bus.o_dm_ready, bus.o_mem_req, bus.o_dm_rdata} !== {2'b10, exp_dm_rdata}) begin
        bad++; $display("FAIL lat%0d_ready got=%h want=%h", lat, {bus.o_dm_ready, bus.o_mem_req, bus.o_dm_rdata}, {2'b10, exp_dm_rdata});
      end
      bus.i_dm_req  = 1'b0;
      bus.i_mem_ack = 1'b0;
      tick();
      total++; if ({bus.o_dm_ready, bus.o_mem_req} !== 2'b00) begin
        bad++; $display("FAIL lat%0d_pulse_width got=%b want=00", lat, {bus.o_dm_ready, bus.o_mem_req});
      end
    end
  endtask

  task automatic test_reset_busy();
    bus.i_dm_req  = 1'b1;
    bus.i_dm_we   = 1'b0;
    bus.i_dm_addr = 20'h00055;
    bus.i_dm_be   = 4'hF;
    tick();
    total++; if ({bus.o_mem_req, bus.o_owner} !== 2'b11) begin
      bad++; $display("FAIL rbusy_grant got=%b want=11", {bus.o_mem_req, bus.o_owner});
    end
    rst          = 1'b1;
    bus.i_dm_req = 1'b0;
    tick();
    total++; if ({mem_s, rsp_s} !== 125'h0) begin bad++; $display("FAIL rbusy_reset_vals got=%h want=0", {mem_s, rsp_s}); end
    rst = 1'b0;
    tick();
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'hFFFF0000;
    total++; if (bus.o_mem_req !== 1'b0) begin bad++; $display("FAIL rbusy_req_low got=%b want=0", bus.o_mem_req); end
    tick();
    bus.i_mem_ack = 1'b0;
    total++; if ({bus.o_dm_ready, bus.o_mem_req, bus.o_dm_rdata} !== 34'h0) begin
      bad++; $display("FAIL rbusy_late_ack got=%h want=0", {bus.o_dm_ready, bus.o_mem_req, bus.o_dm_rdata});
    end
    tick();
    total++; if ({bus.o_dm_ready, bus.o_if_ready, bus.o_mem_req} !== 3'b000) begin
      bad++; $display("FAIL rbusy_quiet got=%b want=000", {bus.o_dm_ready, bus.o_if_ready, bus.o_mem_req});
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_stale_mask();
    test_ack_latency();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
